// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Pipeline MEM stage; runs loads/stores/LL/SC over a registered
//               req/ack bus and stalls the pipeline until the bus completes.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        LLbit_i,
  input  logic        wb_LLbit_we_i,
  input  logic        wb_LLbit_value_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        LLbit_we_o,
  output logic        LLbit_value_o,
  output logic        exc_align_o,
  output logic        stallreq_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  localparam logic [3:0] c_OP_LB  = 4'd1;
  localparam logic [3:0] c_OP_LBU = 4'd2;
  localparam logic [3:0] c_OP_LH  = 4'd3;
  localparam logic [3:0] c_OP_LHU = 4'd4;
  localparam logic [3:0] c_OP_LW  = 4'd5;
  localparam logic [3:0] c_OP_SB  = 4'd6;
  localparam logic [3:0] c_OP_SH  = 4'd7;
  localparam logic [3:0] c_OP_SW  = 4'd8;
  localparam logic [3:0] c_OP_LL  = 4'd9;
  localparam logic [3:0] c_OP_SC  = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DONE  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_op;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_rdata;

  logic        w_llbit_eff, w_is_byte, w_is_half, w_is_word, w_is_store;
  logic        w_is_mem, w_misalign, w_sc_fail, w_accept;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata, w_load_data;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_llbit_eff = wb_LLbit_we_i ? wb_LLbit_value_i : LLbit_i;

  always_comb begin
    w_is_byte  = 1'b0;
    w_is_half  = 1'b0;
    w_is_word  = 1'b0;
    w_is_store = 1'b0;
    case (mem_op_i)
      c_OP_LB, c_OP_LBU:        w_is_byte = 1'b1;
      c_OP_LH, c_OP_LHU:        w_is_half = 1'b1;
      c_OP_LW, c_OP_LL:         w_is_word = 1'b1;
      c_OP_SB: begin            w_is_byte = 1'b1; w_is_store = 1'b1; end
      c_OP_SH: begin            w_is_half = 1'b1; w_is_store = 1'b1; end
      c_OP_SW, c_OP_SC: begin   w_is_word = 1'b1; w_is_store = 1'b1; end
      default: ;
    endcase
  end

  assign w_is_mem   = w_is_byte | w_is_half | w_is_word;
  assign w_misalign = (w_is_half & mem_addr_i[0]) | (w_is_word & (mem_addr_i[1:0] != 2'b00));
  assign w_sc_fail  = (mem_op_i == c_OP_SC) & ~w_llbit_eff;
  assign w_accept   = (r_state == S_IDLE) & ~flush & w_is_mem & ~w_misalign & ~w_sc_fail;

  // Big-endian lanes: byte 0 sits in bits [31:24]
  always_comb begin
    w_sel   = 4'b1111;
    w_wdata = store_data_i;
    if (w_is_byte) begin
      w_sel   = 4'b1000 >> mem_addr_i[1:0];
      w_wdata = {4{store_data_i[7:0]}};
    end else if (w_is_half) begin
      w_sel   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      w_wdata = {2{store_data_i[15:0]}};
    end
  end

  always_comb begin
    case (r_addr_lo)
      2'd0:    w_byte = bus_rdata_i[31:24];
      2'd1:    w_byte = bus_rdata_i[23:16];
      2'd2:    w_byte = bus_rdata_i[15:8];
      default: w_byte = bus_rdata_i[7:0];
    endcase
    w_half = r_addr_lo[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];
    case (r_op)
      c_OP_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
      c_OP_LBU: w_load_data = {24'd0, w_byte};
      c_OP_LH:  w_load_data = {{16{w_half[15]}}, w_half};
      c_OP_LHU: w_load_data = {16'd0, w_half};
      default:  w_load_data = bus_rdata_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= 4'd0;
      r_addr_lo   <= 2'd0;
      r_rdata     <= 32'd0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'd0;
      bus_sel_o   <= 4'd0;
      bus_wdata_o <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op        <= mem_op_i;
          r_addr_lo   <= mem_addr_i[1:0];
          bus_req_o   <= 1'b1;
          bus_we_o    <= w_is_store;
          bus_addr_o  <= mem_addr_i;
          bus_sel_o   <= w_sel;
          bus_wdata_o <= w_wdata;
        end
        S_BUSY: if (bus_ack_i) begin
          bus_req_o <= 1'b0;
          r_rdata   <= w_load_data;
        end
        S_ABORT: if (bus_ack_i) bus_req_o <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next        = r_state;
    wd_o          = wd_i;
    wreg_o        = 1'b0;
    wdata_o       = wdata_i;
    LLbit_we_o    = 1'b0;
    LLbit_value_o = 1'b0;
    exc_align_o   = 1'b0;
    stallreq_o    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (flush) begin
          w_next = S_IDLE;
        end else if (!w_is_mem) begin
          wreg_o = wreg_i;
        end else if (w_misalign) begin
          exc_align_o = 1'b1;
        end else if (w_sc_fail) begin
          wreg_o  = wreg_i;
          wdata_o = 32'd0;
        end else begin
          stallreq_o = 1'b1;
          w_next     = S_BUSY;
        end
      end
      S_BUSY: begin
        stallreq_o = 1'b1;
        if (flush)          w_next = bus_ack_i ? S_IDLE : S_ABORT;
        else if (bus_ack_i) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
        if (!flush) begin
          wreg_o = wreg_i;
          case (r_op)
            c_OP_SB, c_OP_SH, c_OP_SW: wdata_o = wdata_i;
            c_OP_SC: begin
              wdata_o    = 32'd1;
              LLbit_we_o = 1'b1;
            end
            c_OP_LL: begin
              wdata_o       = r_rdata;
              LLbit_we_o    = 1'b1;
              LLbit_value_o = 1'b1;
            end
            default: wdata_o = r_rdata;
          endcase
        end
      end
      S_ABORT: begin
        stallreq_o = 1'b1;
        if (bus_ack_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard-driven bench for mem_access_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam logic [3:0] c_NONE = 4'd0, c_LB = 4'd1, c_LBU = 4'd2, c_LH = 4'd3,
                         c_LHU = 4'd4, c_LW = 4'd5, c_SB = 4'd6, c_SH = 4'd7,
                         c_SW = 4'd8, c_LL = 4'd9, c_SC = 4'd10;

  logic clk, rst, flush;
  logic [3:0] mem_op_i;
  logic [31:0] mem_addr_i, store_data_i, wdata_i, wdata_o;
  logic [4:0] wd_i, wd_o;
  logic wreg_i, LLbit_i, wb_LLbit_we_i, wb_LLbit_value_i;
  logic wreg_o, LLbit_we_o, LLbit_value_o, exc_align_o, stallreq_o;
  logic bus_req_o, bus_we_o, bus_ack_i;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0] bus_sel_o;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .flush(flush),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .store_data_i(store_data_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .LLbit_i(LLbit_i), .wb_LLbit_we_i(wb_LLbit_we_i), .wb_LLbit_value_i(wb_LLbit_value_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .LLbit_we_o(LLbit_we_o), .LLbit_value_o(LLbit_value_o),
    .exc_align_o(exc_align_o), .stallreq_o(stallreq_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] wdata;
    logic        wreg;
    logic        llwe;
    logic        llval;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] wdata;
    logic        wreg, llwe, llval, exc, saw_req, bwe;
    logic [3:0]  sel;
    logic [31:0] bwdata;
    int          stall;
    bit          timeout;
  } obs_t;

  // Drives one op from an IDLE cycle, answers the bus after ack_delay request
  // cycles and records what the DUT shows in its first non-stalled cycle.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rdata,
                        input int ack_delay, output obs_t o);
    int req_cnt = 0;
    bit done = 0;
    o.wdata = 0; o.wreg = 0; o.llwe = 0; o.llval = 0; o.exc = 0;
    o.saw_req = 0; o.bwe = 0; o.sel = 0; o.bwdata = 0; o.stall = 0; o.timeout = 1;
    mem_op_i = op; mem_addr_i = addr; store_data_i = sdata; bus_rdata_i = rdata;
    for (int cyc = 0; cyc < 50 && !done; cyc++) begin
      @(negedge clk);
      if (bus_req_o) begin
        o.saw_req = 1; o.sel = bus_sel_o; o.bwdata = bus_wdata_o; o.bwe = bus_we_o;
        req_cnt++;
        if (req_cnt == ack_delay) bus_ack_i = 1'b1;
      end
      if (!stallreq_o) begin
        o.wdata = wdata_o; o.wreg = wreg_o; o.llwe = LLbit_we_o;
        o.llval = LLbit_value_o; o.exc = exc_align_o;
        o.timeout = 0; done = 1;
      end else begin
        o.stall++;
      end
      @(posedge clk); #1;
      bus_ack_i = 1'b0;
    end
    mem_op_i = c_NONE;
    if (o.stall == 0) begin
      @(negedge clk);
      if (bus_req_o) o.saw_req = 1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; mem_op_i = c_NONE; mem_addr_i = 0; store_data_i = 0;
    wd_i = 0; wreg_i = 0; wdata_i = 0; LLbit_i = 0; wb_LLbit_we_i = 0;
    wb_LLbit_value_i = 0; bus_rdata_i = 0; bus_ack_i = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_tests++;
    if ({bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, stallreq_o} !== 71'd0) begin
      $display("FAIL reset_outputs got req=%b we=%b addr=%h sel=%b wdata=%h stall=%b exp all 0",
               bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, stallreq_o);
      n_fail++;
    end
    @(posedge clk); #1;
    rst = 0; wd_i = 5'h1A; wreg_i = 1; wdata_i = 32'hCAFEF00D;
    @(negedge clk);
    n_tests++;
    if (wd_o !== 5'h1A || wreg_o !== 1'b1 || wdata_o !== 32'hCAFEF00D || stallreq_o !== 1'b0) begin
      $display("FAIL none_passthru got wd=%h wreg=%b wdata=%h stall=%b exp 1a 1 cafef00d 0",
               wd_o, wreg_o, wdata_o, stallreq_o);
      n_fail++;
    end
    @(posedge clk); #1;
    mem_op_i = 4'd13;
    @(negedge clk);
    n_tests++;
    if (stallreq_o !== 1'b0 || wreg_o !== 1'b1 || exc_align_o !== 1'b0) begin
      $display("FAIL op13_as_none got stall=%b wreg=%b exc=%b exp 0 1 0", stallreq_o, wreg_o, exc_align_o);
      n_fail++;
    end
    @(posedge clk); #1;
    mem_op_i = c_NONE;
  endtask

  task automatic test_loads();
    obs_t o; exp_t e;
    wreg_i = 1; wdata_i = 32'h0;
    sb.push_back('{32'hDEADBEEF, 1'b1, 1'b0, 1'b0});
    run_op(c_LW, 32'h100, 32'h0, 32'hDEADBEEF, 2, o);
    e = sb.pop_front();
    n_tests++;
    if (o.timeout || o.wdata !== e.wdata || o.wreg !== e.wreg || o.llwe !== e.llwe) begin
      $display("FAIL lw_result got wdata=%h wreg=%b llwe=%b to=%0d exp %h %b %b",
               o.wdata, o.wreg, o.llwe, o.timeout, e.wdata, e.wreg, e.llwe);
      n_fail++;
    end
    n_tests++;
    if (o.stall != 3 || o.sel !== 4'b1111 || o.bwe !== 1'b0) begin
      $display("FAIL lw_bus got stall=%0d sel=%b we=%b exp 3 1111 0", o.stall, o.sel, o.bwe);
      n_fail++;
    end
    // Scenarios: {op, addr, rdata, expected wdata, expected sel}
    sb.push_back('{32'hFFFFFFF0, 1'b1, 1'b0, 1'b0});
    run_op(c_LB, 32'h103, 32'h0, 32'h000000F0, 1, o);
    e = sb.pop_front();
    n_tests++;
    if (o.wdata !== e.wdata || o.sel !== 4'b0001) begin
      $display("FAIL lb got wdata=%h sel=%b exp %h 0001", o.wdata, o.sel, e.wdata);
      n_fail++;
    end
    sb.push_back('{32'h000000F0, 1'b1, 1'b0, 1'b0});
    run_op(c_LBU, 32'h103, 32'h0, 32'h000000F0, 1, o);
    e = sb.pop_front();
    n_tests++;
    if (o.wdata !== e.wdata) begin
      $display("FAIL lbu got wdata=%h exp %h", o.wdata, e.wdata);
      n_fail++;
    end
    sb.push_back('{32'hFFFF8765, 1'b1, 1'b0, 1'b0});
    run_op(c_LH, 32'h102, 32'h0, 32'h12348765, 1, o);
    e = sb.pop_front();
    n_tests++;
    if (o.wdata !== e.wdata || o.sel !== 4'b0011 || o.exc !== 1'b0) begin
      $display("FAIL lh_hi_addr got wdata=%h sel=%b exc=%b exp %h 0011 0", o.wdata, o.sel, o.exc, e.wdata);
      n_fail++;
    end
    sb.push_back('{32'h00008765, 1'b1, 1'b0, 1'b0});
    run_op(c_LHU, 32'h100, 32'h0, 32'h87651234, 3, o);
    e = sb.pop_front();
    n_tests++;
    if (o.wdata !== e.wdata || o.sel !== 4'b1100 || o.stall != 4) begin
      $display("FAIL lhu got wdata=%h sel=%b stall=%0d exp %h 1100 4", o.wdata, o.sel, o.stall, e.wdata);
      n_fail++;
    end
  endtask

  task automatic test_stores();
    obs_t o; exp_t e;
    wreg_i = 0; wdata_i = 32'h0000ABCD;
    sb.push_back('{32'h0000ABCD, 1'b0, 1'b0, 1'b0});
    run_op(c_SB, 32'h101, 32'h000000AB, 32'h0, 1, o);
    e = sb.pop_front();
    n_tests++;
    if (o.sel !== 4'b0100 || o.bwdata !== 32'hABABABAB || o.bwe !== 1'b1) begin
      $display("FAIL sb_bus got sel=%b wdata=%h we=%b exp 0100 abababab 1", o.sel, o.bwdata, o.bwe);
      n_fail++;
    end
    n_tests++;
    if (o.wdata !== e.wdata || o.wreg !== e.wreg) begin
      $display("FAIL sb_result got wdata=%h wreg=%b exp %h %b", o.wdata, o.wreg, e.wdata, e.wreg);
      n_fail++;
    end
    sb.push_back('{32'h0000ABCD, 1'b0, 1'b0, 1'b0});
    run_op(c_SH, 32'h102, 32'h55661234, 32'h0, 2, o);
    e = sb.pop_front();
    n_tests++;
    if (o.sel !== 4'b0011 || o.bwdata !== 32'h12341234 || o.wdata !== e.wdata) begin
      $display("FAIL sh got sel=%b bwdata=%h wdata=%h exp 0011 12341234 %h", o.sel, o.bwdata, o.wdata, e.wdata);
      n_fail++;
    end
  endtask

  task automatic test_ll_sc();
    obs_t o; exp_t e;
    wreg_i = 1; wdata_i = 32'h0;
    sb.push_back('{32'h00000055, 1'b1, 1'b1, 1'b1});
    run_op(c_LL, 32'h200, 32'h0, 32'h00000055, 1, o);
    e = sb.pop_front();
    n_tests++;
    if (o.wdata !== e.wdata || o.llwe !== e.llwe || o.llval !== e.llval || o.bwe !== 1'b0) begin
      $display("FAIL ll got wdata=%h llwe=%b llval=%b we=%b exp %h %b %b 0",
               o.wdata, o.llwe, o.llval, o.bwe, e.wdata, e.llwe, e.llval);
      n_fail++;
    end
    LLbit_i = 0; wb_LLbit_we_i = 1; wb_LLbit_value_i = 1;
    sb.push_back('{32'h00000001, 1'b1, 1'b1, 1'b0});
    run_op(c_SC, 32'h200, 32'h13572468, 32'h0, 2, o);
    wb_LLbit_we_i = 0; wb_LLbit_value_i = 0;
    e = sb.pop_front();
    n_tests++;
    if (!o.saw_req || o.bwe !== 1'b1 || o.bwdata !== 32'h13572468 || o.sel !== 4'b1111) begin
      $display("FAIL sc_ok_bus got req=%b we=%b wdata=%h sel=%b exp 1 1 13572468 1111",
               o.saw_req, o.bwe, o.bwdata, o.sel);
      n_fail++;
    end
    n_tests++;
    if (o.wdata !== e.wdata || o.wreg !== e.wreg || o.llwe !== e.llwe || o.llval !== e.llval) begin
      $display("FAIL sc_ok_result got wdata=%h wreg=%b llwe=%b llval=%b exp %h %b %b %b",
               o.wdata, o.wreg, o.llwe, o.llval, e.wdata, e.wreg, e.llwe, e.llval);
      n_fail++;
    end
    // Failure cases: {LLbit_i, wb_we, wb_val}; forwarded 0 overrides LLbit_i=1
    for (int i = 0; i < 2; i++) begin
      LLbit_i = (i == 1); wb_LLbit_we_i = (i == 1); wb_LLbit_value_i = 0;
      wdata_i = 32'hFFFF0000;
      sb.push_back('{32'h0, 1'b1, 1'b0, 1'b0});
      run_op(c_SC, 32'h204, 32'h1, 32'h0, 1, o);
      e = sb.pop_front();
      n_tests++;
      if (o.wdata !== e.wdata || o.wreg !== e.wreg || o.llwe !== e.llwe || o.stall != 0 || o.saw_req) begin
        $display("FAIL sc_fail%0d got wdata=%h wreg=%b llwe=%b stall=%0d req=%b exp %h %b %b 0 0",
                 i, o.wdata, o.wreg, o.llwe, o.stall, o.saw_req, e.wdata, e.wreg, e.llwe);
        n_fail++;
      end
    end
    LLbit_i = 0; wb_LLbit_we_i = 0; wdata_i = 32'h0;
  endtask

  task automatic test_misaligned();
    obs_t o; exp_t e;
    logic [3:0]  ops[3]   = '{c_LW, c_LH, c_SC};
    logic [31:0] addrs[3] = '{32'h102, 32'h101, 32'h201};
    wreg_i = 1; LLbit_i = 1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{32'h0, 1'b0, 1'b0, 1'b0});
      run_op(ops[i], addrs[i], 32'h0, 32'h0, 1, o);
      e = sb.pop_front();
      n_tests++;
      if (o.exc !== 1'b1 || o.wreg !== e.wreg || o.llwe !== e.llwe || o.stall != 0 || o.saw_req) begin
        $display("FAIL misalign%0d got exc=%b wreg=%b llwe=%b stall=%0d req=%b exp 1 %b %b 0 0",
                 i, o.exc, o.wreg, o.llwe, o.stall, o.saw_req, e.wreg, e.llwe);
        n_fail++;
      end
    end
    LLbit_i = 0;
  endtask

  task automatic test_back_to_back();
    obs_t o; exp_t e;
    wreg_i = 1;
    sb.push_back('{32'h11112222, 1'b1, 1'b0, 1'b0});
    sb.push_back('{32'h33334444, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 2; i++) begin
      run_op(c_LW, 32'h400 + 32'(i * 4), 32'h0, (i == 0) ? 32'h11112222 : 32'h33334444, 1, o);
      e = sb.pop_front();
      n_tests++;
      if (o.timeout || o.wdata !== e.wdata || o.stall != 2) begin
        $display("FAIL b2b%0d got wdata=%h stall=%0d exp %h 2", i, o.wdata, o.stall, e.wdata);
        n_fail++;
      end
    end
  endtask

  task automatic test_flush_abort();
    int  req_cyc = 0;
    bit  bad = 0;
    wreg_i = 1; wdata_i = 32'h11; mem_op_i = c_LW; mem_addr_i = 32'h300;
    bus_rdata_i = 32'h99999999;
    @(posedge clk); #1;
    flush = 1; mem_op_i = c_NONE;
    @(negedge clk);
    n_tests++;
    if (bus_req_o !== 1'b1 || stallreq_o !== 1'b1) begin
      $display("FAIL flush_in_busy got req=%b stall=%b exp 1 1", bus_req_o, stallreq_o);
      n_fail++;
    end
    @(posedge clk); #1;
    flush = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus_ack_i = 1;
      @(negedge clk);
      if (bus_req_o && stallreq_o) req_cyc++;
      if (wreg_o !== 1'b0 || LLbit_we_o !== 1'b0) bad = 1;
      @(posedge clk); #1;
      bus_ack_i = 0;
    end
    n_tests++;
    if (req_cyc != 3 || bad) begin
      $display("FAIL abort_hold got req_cycles=%0d wreg_seen=%0d exp 3 0", req_cyc, bad);
      n_fail++;
    end
    @(negedge clk);
    n_tests++;
    if (bus_req_o !== 1'b0 || stallreq_o !== 1'b0 || wdata_o !== 32'h11) begin
      $display("FAIL abort_exit got req=%b stall=%b wdata=%h exp 0 0 00000011", bus_req_o, stallreq_o, wdata_o);
      n_fail++;
    end
    @(posedge clk); #1;
    // flush and ack in the same BUSY cycle
    mem_op_i = c_LW; mem_addr_i = 32'h304; bus_rdata_i = 32'h77;
    @(posedge clk); #1;
    flush = 1; bus_ack_i = 1; mem_op_i = c_NONE;
    @(posedge clk); #1;
    flush = 0; bus_ack_i = 0;
    @(negedge clk);
    n_tests++;
    if (bus_req_o !== 1'b0 || stallreq_o !== 1'b0 || LLbit_we_o !== 1'b0 || wdata_o !== 32'h11) begin
      $display("FAIL flush_ack got req=%b stall=%b llwe=%b wdata=%h exp 0 0 0 00000011",
               bus_req_o, stallreq_o, LLbit_we_o, wdata_o);
      n_fail++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_busy();
    mem_op_i = c_SW; mem_addr_i = 32'h500; store_data_i = 32'h1;
    @(posedge clk); #1;
    mem_op_i = c_NONE;
    @(negedge clk);
    n_tests++;
    if (bus_req_o !== 1'b1) begin
      $display("FAIL rst_busy_pre got req=%b exp 1", bus_req_o);
      n_fail++;
    end
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    n_tests++;
    if (bus_req_o !== 1'b0 || stallreq_o !== 1'b0 || bus_we_o !== 1'b0 || bus_addr_o !== 32'h0) begin
      $display("FAIL rst_busy got req=%b stall=%b we=%b addr=%h exp 0 0 0 0",
               bus_req_o, stallreq_o, bus_we_o, bus_addr_o);
      n_fail++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_ll_sc();
    test_misaligned();
    test_back_to_back();
    test_flush_abort();
    test_reset_busy();
    test_loads();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
